bus_transfer_controller: RTL
============================

// Module: bus_transfer_controller
// PURPOSE
//  Bus-side sequencer that drives the control pins of the 8-bit tri-state data bus.
//  It issues active-low OE to exactly one source (a '574 register or '541 buffer) and a
//  low-to-high CP edge to one destination '574 register.
//  It accepts one transfer request (src,dst) per valid/ready handshake and guarantees
//  break-before-make: no two sources are ever driven together.
//  It sits between the instruction decoder and the register file/ALU bus drivers.
// PARAMETERS
//  N_SRC          8  number of bus sources (oe_n width), 2..16
//  N_DST          8  number of bus destinations (cp width), 2..16
//  SETTLE_CYCLES  1  cycles OE is held low before the CP edge, 1..15
//  SRC_W          3  width of req_src, = clog2(N_SRC)
//  DST_W          3  width of req_dst, = clog2(N_DST)
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst_n      in   1      synchronous reset, active low
//  req_valid  in   1      transfer request present
//  req_ready  out  1      controller can accept; high only in IDLE
//  req_src    in   SRC_W  source index to enable onto bus
//  req_dst    in   DST_W  destination index to clock
//  bus_d      in   8      resolved bus value (for capture/debug)
//  oe_n       out  N_SRC  per-source output enable, active low, at most one low
//  cp         out  N_DST  per-destination clock, one-hot pulse, else all low
//  last_data  out  8      bus value sampled in the CAPTURE cycle
//  done       out  1      one-cycle pulse: transfer finished (or rejected)
//  err        out  1      one-cycle pulse with done: request index out of range
// BEHAVIOUR
//  Reset: the clock is clk; reset is rst_n, synchronous and active-low. At the first
//   posedge with rst_n=0: state=IDLE, oe_n=all 1, cp=all 0, last_data=0, done=0,
//   err=0, and latched src/dst=0.
//  Handshake: accept on a posedge with req_valid & req_ready. req_ready = (state==IDLE),
//   decoded from state. src/dst are latched on accept; the inputs may change afterwards.
//  FSM: IDLE -> DRIVE (SETTLE_CYCLES cycles) -> CAPTURE (1) -> HOLD (1) -> GAP (1) -> IDLE.
//   DRIVE:   oe_n[src]=0, cp=0, settle counter runs.
//   CAPTURE: oe_n[src]=0, cp[dst]=1, last_data<=bus_d at the end of the cycle.
//   HOLD:    oe_n[src]=0, cp=0. This gives hold time after the CP rising edge.
//   GAP:     oe_n=all 1, cp=0, done=1. This is the dead cycle before the next driver.
//  Latency: accept at edge t -> CP high during cycle t+1+SETTLE_CYCLES -> done during
//   cycle t+SETTLE_CYCLES+3 -> req_ready again at t+SETTLE_CYCLES+4.
//   Back-to-back throughput is one transfer per SETTLE_CYCLES+4 cycles.
//  Outputs oe_n, cp, done and err come straight from flops and never glitch.
//   oe_n is never low in IDLE or GAP.
//  src==dst is legal (edge-triggered destination).
//  Out of range (req_src>=N_SRC or req_dst>=N_DST): the request is accepted and goes
//   straight to GAP. No OE or CP is issued, done=1 and err=1, last_data is unchanged.
//  Reset mid-transfer takes priority over every state. The CP pulse may be truncated,
//   and the destination contents are then undefined, which is accepted.
//  req_valid while busy is ignored, not queued; the requester holds it until ready.
// STRUCTURE
//  Shared include bus_ctrl_defs.vh holds the state encodings (IDLE, DRIVE, CAPTURE, HOLD,
//   GAP) and the clog2 helper for SRC_W/DST_W.
//  One sub-module, onehot_strobe_decoder (index, en -> one-hot vector):
//   - instanced twice, for oe_n (inverted) and for cp;
//   - outputs registered in the parent.
// TESTING
//  1 Reset: hold rst_n=0 for 2 edges mid-CAPTURE -> next cycle oe_n=8'hFF, cp=0,
//    req_ready=1, done=0.
//  2 Single: src=3, dst=5, bus_d=8'hA5, SETTLE=1 -> oe_n=8'hF7 for 3 cycles;
//    cp=8'h20 in the 2nd of them; last_data=8'hA5; done pulses once, 4 cycles after accept.
//  3 Back-to-back: hold req_valid high with (1->2) then (2->1) -> accepts are
//    5 cycles apart; oe_n is all 1 for at least one cycle between them; never two bits low.
//  4 Range: N_SRC=6, req_src=7 -> oe_n and cp stay idle; done=err=1 one cycle after
//    accept; last_data held.
//  5 Settle: SETTLE_CYCLES=3, src=0, dst=0 -> CP edge 4 cycles after accept;
//    oe_n[0] low for 5 cycles; src==dst completes normally.
//  6 Assertions, always on: $onehot0(~oe_n); $onehot0(cp); cp!=0 implies oe_n!=all 1;
//    done implies state was GAP.

Source files
------------

// File: rtl/bus_transfer_controller_pkg.sv
// Shared definitions for the bus transfer controller: FSM state encoding
// and the index-width helper used to size the request fields.
package bus_transfer_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    // Settle counter width; covers SETTLE_CYCLES up to 15.
    localparam int CNT_W = 4;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_transfer_controller_if.sv
// Request handshake and bus control pins between the decoder side (master)
// and the transfer controller (slave).
interface bus_transfer_controller_if #(
    parameter int N_SRC = 8,
    parameter int N_DST = 8,
    parameter int SRC_W = 3,
    parameter int DST_W = 3
);
    // A request transfers on a posedge where req_valid and req_ready are both
    // high; req_src/req_dst must be stable while req_valid waits for req_ready,
    // and a request seen while req_ready is low is ignored, never queued.
    logic             req_valid;
    logic             req_ready;
    logic [SRC_W-1:0] req_src;
    logic [DST_W-1:0] req_dst;
    logic [7:0]       bus_d;
    logic [N_SRC-1:0] oe_n;
    logic [N_DST-1:0] cp;
    logic [7:0]       last_data;
    logic             done;
    logic             err;

    modport master (
        output req_valid, req_src, req_dst, bus_d,
        input  req_ready, oe_n, cp, last_data, done, err
    );

    modport slave (
        input  req_valid, req_src, req_dst, bus_d,
        output req_ready, oe_n, cp, last_data, done, err
    );
endinterface

// File: rtl/bus_transfer_controller_onehot_strobe_decoder.sv
// Index-to-one-hot decoder with enable; all-zero when disabled or when the
// index is past the last strobe.
module onehot_strobe_decoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [W-1:0] index,
    input  logic         en,
    output logic [N-1:0] strobe
);
    always_comb begin
        strobe = '0;
        for (int i = 0; i < N; i++) begin
            strobe[i] = en && (index == W'(i));
        end
    end
endmodule

// File: rtl/bus_transfer_controller.sv
// Sequences one source OE and one destination CP edge per accepted request,
// with a dead cycle between drivers so two sources never share the bus.
module bus_transfer_controller
    import bus_transfer_controller_pkg::*;
#(
    parameter int N_SRC         = 8,
    parameter int N_DST         = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int SRC_W         = clog2(N_SRC),
    parameter int DST_W         = clog2(N_DST)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bus_transfer_controller_if.slave  bus,
    output state_t                    state_dbg
);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [SRC_W-1:0] src_q, src_nxt;
    logic [DST_W-1:0] dst_q, dst_nxt;
    logic             req_ready, accept, oob, err_nxt, drive_en, cp_en;
    logic [N_SRC-1:0] oe_dec, oe_n_q;
    logic [N_DST-1:0] cp_dec, cp_q;
    logic             done_q, err_q;
    logic [7:0]       last_q;

    assign req_ready = (state == ST_IDLE);
    assign accept    = bus.req_valid && req_ready;
    assign oob       = (int'(bus.req_src) >= N_SRC) || (int'(bus.req_dst) >= N_DST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        src_nxt   = src_q;
        dst_nxt   = dst_q;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    src_nxt = bus.req_src;
                    dst_nxt = bus.req_dst;
                    cnt_nxt = '0;
                    if (oob) begin
                        state_nxt = ST_GAP;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = ST_CAPTURE;
                else cnt_nxt = cnt_q + 1'b1;
            end
            ST_CAPTURE: state_nxt = ST_HOLD;
            ST_HOLD:    state_nxt = ST_GAP;
            ST_GAP:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        // Strobes are decoded from the next state so the pins come out of flops.
        drive_en = (state_nxt == ST_DRIVE) || (state_nxt == ST_CAPTURE) || (state_nxt == ST_HOLD);
        cp_en    = (state_nxt == ST_CAPTURE);
    end

    onehot_strobe_decoder #(.N(N_SRC), .W(SRC_W)) u_oe_dec (
        .index (src_nxt),
        .en    (drive_en),
        .strobe(oe_dec)
    );

    onehot_strobe_decoder #(.N(N_DST), .W(DST_W)) u_cp_dec (
        .index (dst_nxt),
        .en    (cp_en),
        .strobe(cp_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt_q  <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            oe_n_q <= '1;
            cp_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            last_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt_q  <= cnt_nxt;
            src_q  <= src_nxt;
            dst_q  <= dst_nxt;
            oe_n_q <= ~oe_dec;
            cp_q   <= cp_dec;
            done_q <= (state_nxt == ST_GAP);
            err_q  <= err_nxt;
            if (state == ST_CAPTURE) last_q <= bus.bus_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.oe_n      = oe_n_q;
    assign bus.cp        = cp_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.last_data = last_q;
    assign state_dbg     = state;

    a_one_source:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~oe_n_q));
    a_one_dest:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(cp_q));
    a_cp_driven:   assert property (@(posedge clk) disable iff (!rst_n) (|cp_q) |-> !(&oe_n_q));
    a_done_in_gap: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> (state == ST_GAP));
    a_idle_quiet:  assert property (@(posedge clk) disable iff (!rst_n)
                                    ((state == ST_IDLE) || (state == ST_GAP)) |-> (&oe_n_q));
endmodule
